serial_rx_wb: RTL
=================

SERIAL_RX_WB -- requirements
Module: serial_rx_wb

Interface
REQ-001 Parameter BIT_CLKS, default 4, CLK_I cycles per serial bit (legal range 2..255).
REQ-002 Parameter WORD_BITS, default 10, bits per serial frame (legal range 1..16).
REQ-003 Parameter FIFO_DEPTH, default 8, received-word FIFO depth (power of two, 2..64).
REQ-004 CLK_I  in  1  single clock; all logic on its rising edge.
REQ-005 RST_I  in  1  reset, synchronous, active-high.
REQ-006 CYC_I  in  1  Wishbone bus cycle.
REQ-007 STB_I  in  1  Wishbone strobe.
REQ-008 WE_I  in  1  Wishbone write enable.
REQ-009 ADR_I  in  32  Wishbone byte address; only ADR_I[3:2] decoded.
REQ-010 DAT_I  in  32  Wishbone write data.
REQ-011 DAT_O  out  32  Wishbone read data.
REQ-012 ACK_O  out  1  Wishbone acknowledge.
REQ-013 ser_ena_i  in  1  frame enable from the upstream serializer; high = idle, low = frame in flight.
REQ-014 ser_data_i  in  1  serial data, LSB first.
REQ-015 irq_o  out  1  high while FIFO is non-empty.

Function
REQ-016 Receive FSM states: IDLE, ARMED, HALF, SAMPLE, PUSH.
REQ-017 IDLE -> ARMED when ser_ena_i is sampled 1; ARMED -> HALF when ser_ena_i is sampled 0, i.e. on the falling edge only (a frame never starts while ser_ena_i is constantly low).
REQ-018 HALF: wait BIT_CLKS/2 cycles, then sample bit 0 and enter SAMPLE.
REQ-019 SAMPLE: sample the next bit every BIT_CLKS cycles into shift register bit index i (LSB first); after bit WORD_BITS-1 enter PUSH.
REQ-020 PUSH: write the word, zero-extended to 16 bits, into the FIFO in one cycle, then go to ARMED.
REQ-021 ser_ena_i returning to 1 before the last bit is sampled aborts the frame: no push, sticky frame-error flag set, go to ARMED.
REQ-022 PUSH with FIFO full: word dropped, sticky overflow flag set, FIFO contents unchanged.
REQ-023 Register map: 0x0 DATA (read pops, DAT_O[15:0] = head word, DAT_O[31] = 1 if the FIFO was empty, in which case nothing pops and DAT_O[15:0] = 0); 0x4 STATUS; 0x8 FRAMECNT (REQ-033).
REQ-024 STATUS read: [0] empty, [1] full, [2] overflow, [3] frame-error, [14:8] FIFO count, other bits 0.
REQ-025 Writing STATUS with DAT_I[2]/DAT_I[3] = 1 clears overflow/frame-error; writes to DATA and to unmapped addresses are acknowledged and ignored.
REQ-026 ACK_O asserts exactly one cycle after CYC_I & STB_I are sampled high, for one cycle only; DAT_O is valid in that cycle.
REQ-027 A strobe held high produces one ACK per two cycles (ACK, then re-sample), with one pop per acknowledged DATA read.
REQ-028 Push and pop in the same cycle: both occur and the count is unchanged; on a full FIFO the push succeeds because the pop frees the slot.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; count saturates at no value beyond FIFO_DEPTH.

Reset
REQ-030 While RST_I is high: FSM in IDLE, FIFO empty, pointers 0, flags 0, ACK_O = 0, DAT_O = 0, irq_o = 0.
REQ-031 RST_I asserted mid-frame discards the partial word; after release a new frame requires a fresh 1 -> 0 transition on ser_ena_i.
REQ-032 RST_I asserted during a bus cycle suppresses the pending ACK.

Configuration
REQ-033 Macro SERIAL_RX_FRAMECNT_EN defined: 16-bit wrapping counter of successfully pushed frames, readable at 0x8 in DAT_O[15:0], cleared by any write to 0x8 and by reset; undefined: no counter, 0x8 reads 0.

Verification
REQ-034 Reset held for 5 cycles, then STATUS read -> DAT_O = 0x0000_0001, irq_o = 0.
REQ-035 BIT_CLKS = 4, ser_ena_i 1 -> 0, 10 bits of 0x201 LSB first -> irq_o = 1, STATUS count = 1, DATA read = 0x0000_0201, then empty = 1.
REQ-036 9 frames 0x001..0x009 with no reads -> full = 1, overflow = 1, the 8 reads return 0x001..0x008 in order.
REQ-037 ser_ena_i returns high after 5 bits -> no push, frame-error = 1; write 0x8 to STATUS -> frame-error = 0.
REQ-038 DATA read on an empty FIFO -> DAT_O = 0x8000_0000 with ACK_O exactly one cycle long.
REQ-039 RST_I pulse after bit 3 of a frame -> FIFO empty, and the rest of the frame is ignored; next full frame 0x155 read back as 0x155 (FRAMECNT = 1 when SERIAL_RX_FRAMECNT_EN is defined).

Source files
------------

// File: rtl/serial_rx_wb.sv
// Serial frame receiver (falling-edge start, mid-bit sampling, LSB first) with a Wishbone-readable word FIFO.
// Optional frame counter at 0x8 is built when SERIAL_RX_FRAMECNT_EN is defined.
`timescale 1ns/1ps

module serial_rx_wb #(
   parameter int BIT_CLKS   = 4,
   parameter int WORD_BITS  = 10,
   parameter int FIFO_DEPTH = 8
)(
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        CYC_I,
   input  logic        STB_I,
   input  logic        WE_I,
   input  logic [31:0] ADR_I,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   output logic        ACK_O,
   input  logic        ser_ena_i,
   input  logic        ser_data_i,
   output logic        irq_o
);

   localparam int         AW       = $clog2(FIFO_DEPTH);
   localparam int         CW       = AW + 1;
   localparam logic [7:0] HALF_M1  = 8'(BIT_CLKS / 2 - 1);
   localparam logic [7:0] BIT_M1   = 8'(BIT_CLKS - 1);
   localparam logic [3:0] LAST_IDX = 4'(WORD_BITS - 1);
   localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, ARMED, HALF, SAMPLE, PUSH} state_t;

   state_t        state;
   logic [7:0]    cnt;
   logic [3:0]    bit_idx;
   logic [15:0]   sreg;
   logic          ena_prev;

   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          ovf, ferr;
`ifdef SERIAL_RX_FRAMECNT_EN
   logic [15:0]   frame_cnt;
`endif

   logic          samp_tick, last_bit, abort;
   logic          empty, full, push_req, push_ok, push_drop, pop;
   logic          bus_req, rd_req, wr_req;
   logic [1:0]    adr;
   logic [31:0]   status, rd_data;
   logic          unused;

   assign unused = ^{ADR_I[31:4], ADR_I[1:0], DAT_I[31:4], DAT_I[1:0]};

   // receive path
   assign samp_tick = (state == HALF   && cnt == HALF_M1) ||
                      (state == SAMPLE && cnt == BIT_M1);
   assign last_bit  = samp_tick && bit_idx == LAST_IDX;
   // a frame that completes its last sample in the same cycle the enable rises is kept
   assign abort     = (state == HALF || state == SAMPLE) && ser_ena_i && !last_bit;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         sreg     <= '0;
         ena_prev <= 1'b0;
      end else begin
         ena_prev <= ser_ena_i;
         case (state)
            IDLE:  if (ser_ena_i) state <= ARMED;
            // ena_prev makes the start strictly a 1 -> 0 transition
            ARMED: if (ena_prev && !ser_ena_i) begin
               state   <= HALF;
               cnt     <= '0;
               bit_idx <= '0;
               sreg    <= '0;
            end
            HALF, SAMPLE: begin
               if (abort) begin
                  state <= ARMED;
               end else if (samp_tick) begin
                  sreg[bit_idx] <= ser_data_i;
                  cnt           <= '0;
                  bit_idx       <= bit_idx + 4'd1;
                  state         <= last_bit ? PUSH : SAMPLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            PUSH:    state <= ARMED;
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO and bus
   assign adr       = ADR_I[3:2];
   assign bus_req   = CYC_I && STB_I && !ACK_O;
   assign rd_req    = bus_req && !WE_I;
   assign wr_req    = bus_req && WE_I;
   assign empty     = count == '0;
   assign full      = count == DEPTH;
   assign pop       = rd_req && adr == 2'd0 && !empty;
   assign push_req  = state == PUSH;
   assign push_ok   = push_req && (!full || pop);
   assign push_drop = push_req && !push_ok;
   assign irq_o     = !empty;

   always_comb begin
      status       = '0;
      status[0]    = empty;
      status[1]    = full;
      status[2]    = ovf;
      status[3]    = ferr;
      status[14:8] = 7'(count);
   end

   always_comb begin
      rd_data = '0;
      case (adr)
         2'd0:    rd_data = empty ? 32'h8000_0000 : {16'h0, mem[rd_ptr]};
         2'd1:    rd_data = status;
`ifdef SERIAL_RX_FRAMECNT_EN
         2'd2:    rd_data = {16'h0, frame_cnt};
`endif
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (push_ok) mem[wr_ptr] <= sreg;
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         ACK_O  <= 1'b0;
         DAT_O  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         ferr   <= 1'b0;
      end else begin
         ACK_O <= bus_req;
         DAT_O <= rd_req ? rd_data : '0;
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop);
         // a new event in the same cycle as a clear stays visible
         ovf   <= (ovf  && !(wr_req && adr == 2'd1 && DAT_I[2])) || push_drop;
         ferr  <= (ferr && !(wr_req && adr == 2'd1 && DAT_I[3])) || abort;
      end
   end

`ifdef SERIAL_RX_FRAMECNT_EN
   always_ff @(posedge CLK_I) begin
      if (RST_I)                       frame_cnt <= '0;
      else if (wr_req && adr == 2'd2)  frame_cnt <= '0;
      else if (push_ok)                frame_cnt <= frame_cnt + 16'd1;
   end
`endif

endmodule
